wb_daq_multichannel: RTL and testbench

WB_DAQ_MULTICHANNEL -- requirements
Module: wb_daq_multichannel

---
 rtl/wb_daq_multichannel_if.sv | 27 ++
 rtl/wb_daq_multichannel.sv | 191 +++++++++++++++++++
 tb/tb_wb_daq_multichannel.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_daq_multichannel_if.sv
// SRAM-writer handshake of the multichannel DAQ: packed word, source channel,
// one-cycle write request and the writer's word-complete pulse.
interface wb_daq_multichannel_if #(
  parameter int dw           = 32,
  parameter int NUM_CHANNELS = 4
);
  localparam int CW = $clog2(NUM_CHANNELS);

  logic [dw-1:0] data_out;
  logic          start_sram;
  logic [CW-1:0] channel_id;
  logic          data_done;

  modport master (
    output data_out,
    output start_sram,
    output channel_id,
    input  data_done
  );

  modport slave (
    input  data_out,
    input  start_sram,
    input  channel_id,
    output data_done
  );
endinterface

// File: rtl/wb_daq_multichannel.sv
// Multichannel ADC sample packer with per-channel FIFOs and a round-robin burst arbiter
// feeding an SRAM writer. Define WB_DAQ_MULTICHANNEL_OVERFLOW_EN for sticky overflow flags.
module wb_daq_multichannel #(
  parameter int dw             = 32,
  parameter int ADC_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int NUM_CHANNELS   = 4,
  parameter int CW             = $clog2(NUM_CHANNELS),
  parameter int FW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                     wb_clk,
  input  logic                                     wb_rst,
  input  logic                                     master_enable,
  input  logic [NUM_CHANNELS-1:0]                  channel_enable,
  input  logic [NUM_CHANNELS-1:0]                  signed_data,
  input  logic [NUM_CHANNELS*ADC_DATA_WIDTH-1:0]   adc_data_in,
  input  logic [NUM_CHANNELS-1:0]                  adc_data_ready,
  input  logic [FW-1:0]                            fifo_number_samples_terminal,
  output logic [NUM_CHANNELS-1:0]                  fifo_empty,
  output logic [NUM_CHANNELS-1:0]                  overflow,
  wb_daq_multichannel_if.master                    sram
);
  localparam int SPW = dw / ADC_DATA_WIDTH;
  localparam int SCW = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FW-1:0] DEPTH_W = FW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ARB, POP, START, WAIT_DONE} state_t;
  state_t state_reg, state_next;

  logic [NUM_CHANNELS-1:0] active, push, pop, full;
  logic [dw-1:0]           word   [NUM_CHANNELS];
  logic [PW-1:0]           wr_ptr [NUM_CHANNELS];
  logic [PW-1:0]           rd_ptr [NUM_CHANNELS];
  logic [FW-1:0]           count  [NUM_CHANNELS];
  logic [dw-1:0]           mem    [NUM_CHANNELS][FIFO_DEPTH];

  logic [CW-1:0] burst_ch_reg, last_served_reg, pick, rr_idx;
  logic [FW-1:0] burst_cnt_reg, terminal;
  logic          pick_valid;

  assign active = {NUM_CHANNELS{master_enable}} & channel_enable;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [ADC_DATA_WIDTH-1:0] sample;
      logic [SCW-1:0]            sample_cnt_reg;
      logic [dw-1:0]             word_reg;
      logic                      push_reg;
      logic [FW-1:0]             count_reg;
      logic [PW-1:0]             wr_ptr_reg, rd_ptr_reg;
      logic                      push_ok, pop_ok;

      // Offset binary to two's complement is just a flip of the sample MSB.
      assign sample = adc_data_in[gi*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]
                      ^ (ADC_DATA_WIDTH'(signed_data[gi]) << (ADC_DATA_WIDTH-1));

      always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
          sample_cnt_reg <= '0;
          word_reg       <= '0;
          push_reg       <= 1'b0;
        end else begin
          push_reg <= 1'b0;
          if (!active[gi]) begin
            sample_cnt_reg <= '0;
          end else if (adc_data_ready[gi]) begin
            word_reg[sample_cnt_reg*ADC_DATA_WIDTH +: ADC_DATA_WIDTH] <= sample;
            if (sample_cnt_reg == SCW'(SPW-1)) begin
              sample_cnt_reg <= '0;
              push_reg       <= 1'b1;
            end else begin
              sample_cnt_reg <= sample_cnt_reg + SCW'(1);
            end
          end
        end
      end

      // A push into a full FIFO is dropped even if a pop happens in the same cycle.
      assign full[gi] = (count_reg == DEPTH_W);
      assign push_ok  = push_reg && !full[gi];
      assign pop_ok   = pop[gi] && (count_reg != '0);

      always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
          count_reg  <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
          if (push_ok && !pop_ok)      count_reg <= count_reg + FW'(1);
          else if (pop_ok && !push_ok) count_reg <= count_reg - FW'(1);
        end
      end

      assign push[gi]       = push_ok;
      assign word[gi]       = word_reg;
      assign wr_ptr[gi]     = wr_ptr_reg;
      assign rd_ptr[gi]     = rd_ptr_reg;
      assign count[gi]      = count_reg;
      assign fifo_empty[gi] = (count_reg == '0);
      assign pop[gi]        = (state_reg == POP) && (burst_ch_reg == CW'(gi));

`ifdef WB_DAQ_MULTICHANNEL_OVERFLOW_EN
      logic overflow_reg;
      always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst)                               overflow_reg <= 1'b0;
        else if (!channel_enable[gi])             overflow_reg <= 1'b0;
        else if (push_reg && full[gi])            overflow_reg <= 1'b1;
      end
      assign overflow[gi] = overflow_reg;
`else
      assign overflow[gi] = 1'b0;
`endif
    end
  endgenerate

  always_ff @(posedge wb_clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= word[c];
  end

  always_comb begin
    terminal = fifo_number_samples_terminal;
    if (fifo_number_samples_terminal == '0)        terminal = FW'(1);
    else if (fifo_number_samples_terminal > DEPTH_W) terminal = DEPTH_W;
  end

  // Scan farthest-first so the channel nearest after last_served wins.
  always_comb begin
    pick       = last_served_reg;
    pick_valid = 1'b0;
    rr_idx     = '0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      rr_idx = CW'((int'(last_served_reg) + i) % NUM_CHANNELS);
      if (active[rr_idx] && (count[rr_idx] >= terminal)) begin
        pick       = rr_idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      state_next = ARB;
      ARB:       state_next = pick_valid ? POP : IDLE;
      POP:       state_next = START;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: if (sram.data_done) state_next = (burst_cnt_reg == FW'(1)) ? IDLE : POP;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    sram.start_sram = (state_reg == START);
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      burst_ch_reg    <= '0;
      burst_cnt_reg   <= '0;
      last_served_reg <= CW'(NUM_CHANNELS-1);
      sram.data_out   <= '0;
      sram.channel_id <= '0;
    end else begin
      case (state_reg)
        ARB: if (pick_valid) begin
          burst_ch_reg  <= pick;
          burst_cnt_reg <= terminal;
        end
        POP: begin
          sram.data_out   <= mem[burst_ch_reg][rd_ptr[burst_ch_reg]];
          sram.channel_id <= burst_ch_reg;
        end
        WAIT_DONE: if (sram.data_done) begin
          burst_cnt_reg <= burst_cnt_reg - FW'(1);
          if (burst_cnt_reg == FW'(1)) last_served_reg <= burst_ch_reg;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_daq_multichannel.sv
// Self-checking bench for wb_daq_multichannel: random sample words against a queue-based
// model of the per-channel FIFOs, round-robin service order and overflow behaviour.
module tb_wb_daq_multichannel;
  localparam int NCH = 4, ADW = 8, DW = 32, DEPTH = 16, FW = 5;
`ifdef WB_DAQ_MULTICHANNEL_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             wb_clk = 1'b0;
  logic             wb_rst = 1'b1;
  logic             master_enable = 1'b1;
  logic [NCH-1:0]   channel_enable = '1;
  logic [NCH-1:0]   signed_data = '0;
  logic [NCH*ADW-1:0] adc_data_in = '0;
  logic [NCH-1:0]   adc_data_ready = '0;
  logic [FW-1:0]    term = 5'd16;
  logic [NCH-1:0]   fifo_empty, overflow;

  int passed = 0, total = 0, fails = 0;
  logic [31:0] exp_q [NCH][$];
  logic [NCH-1:0] model_ovf = '0;

  always #5 wb_clk = ~wb_clk;

  wb_daq_multichannel_if #(.dw(DW), .NUM_CHANNELS(NCH)) sram ();

  wb_daq_multichannel #(.dw(DW), .ADC_DATA_WIDTH(ADW), .FIFO_DEPTH(DEPTH), .NUM_CHANNELS(NCH)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .master_enable(master_enable),
    .channel_enable(channel_enable), .signed_data(signed_data),
    .adc_data_in(adc_data_in), .adc_data_ready(adc_data_ready),
    .fifo_number_samples_terminal(term), .fifo_empty(fifo_empty),
    .overflow(overflow), .sram(sram)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  // Offset binary -> two's complement by adding half range modulo 256.
  function automatic logic [31:0] model_word(input logic [31:0] samples, input bit sgn);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      int s;
      s = int'((samples >> (8*i)) & 32'hFF);
      if (sgn) s = (s + 128) % 256;
      w = w | (32'(s) << (8*i));
    end
    return w;
  endfunction

  task automatic push_model(input int ch, input logic [31:0] w);
    if (exp_q[ch].size() < DEPTH) exp_q[ch].push_back(w);
    else if (OVF_EN) model_ovf[ch] = 1'b1;
  endtask

  task automatic send_word(input int ch, input logic [31:0] samples);
    for (int i = 0; i < 4; i++) begin
      adc_data_in[ch*ADW +: ADW] = samples[8*i +: 8];
      adc_data_ready[ch] = 1'b1;
      step();
      adc_data_ready[ch] = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    push_model(ch, model_word(samples, signed_data[ch]));
  endtask

  task automatic wait_start(input int exp_ch);
    bit found = 1'b0;
    logic [31:0] expw;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (sram.start_sram === 1'b1) found = 1'b1;
    end
    check("start_seen", 32'(found), 32'd1);
    if (found) begin
      expw = 32'hDEADBEEF;
      if (exp_q[exp_ch].size() > 0) expw = exp_q[exp_ch].pop_front();
      check("channel_id", 32'(sram.channel_id), 32'(exp_ch));
      check("data_out", sram.data_out, expw);
      step();
      check("start_one_cycle", 32'(sram.start_sram), 32'd0);
    end
  endtask

  task automatic send_done();
    sram.data_done = 1'b1;
    step();
    sram.data_done = 1'b0;
  endtask

  task automatic serve(input int ch);
    wait_start(ch);
    send_done();
  endtask

  task automatic no_start(input int n, input string tag);
    int cnt = 0;
    repeat (n) begin
      step();
      if (sram.start_sram !== 1'b0) cnt++;
    end
    check(tag, 32'(cnt), 32'd0);
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    model_ovf = '0;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    step();
    step();
    wb_rst = 1'b0;
    clear_model();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int ch;
    sram.data_done = 1'b0;
    #2;
    check("rst_fifo_empty", 32'(fifo_empty), 32'hF);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_start", 32'(sram.start_sram), 32'h0);
    check("rst_data_out", sram.data_out, 32'h0);
    check("rst_channel_id", 32'(sram.channel_id), 32'h0);
    step();
    wb_rst = 1'b0;
    step();

    // Packing order and sign conversion on channel 0
    term = 5'd1;
    send_word(0, 32'h44332211);
    serve(0);
    check("pack_unsigned", sram.data_out, 32'h44332211);
    signed_data[0] = 1'b1;
    send_word(0, 32'h44332211);
    serve(0);
    check("pack_signed", sram.data_out, 32'hC4B3A291);
    check("ch0_empty", 32'(fifo_empty[0]), 32'd1);
    signed_data[0] = 1'b0;

    // Terminal 0 behaves as 1
    term = 5'd0;
    send_word(3, $urandom);
    serve(3);

    // Terminal 2: no service at one word, a two-word burst at two
    term = 5'd2;
    send_word(1, $urandom);
    no_start(10, "t2_below_threshold");
    send_word(1, $urandom);
    serve(1);
    serve(1);
    step();
    check("t2_ch1_empty", 32'(fifo_empty[1]), 32'd1);

    // Round robin after reset: ch0, then ch2, then ch0 again
    do_reset();
    term = 5'd16;
    send_word(0, $urandom);
    send_word(2, $urandom);
    send_word(0, $urandom);
    step();
    step();
    term = 5'd1;
    serve(0);
    serve(2);
    serve(0);

    // A partial word is discarded when its channel goes inactive
    for (int i = 0; i < 2; i++) begin
      adc_data_in[2*ADW +: ADW] = 8'($urandom);
      adc_data_ready[2] = 1'b1;
      step();
      adc_data_ready[2] = 1'b0;
    end
    channel_enable[2] = 1'b0;
    step();
    channel_enable[2] = 1'b1;
    send_word(2, $urandom);
    serve(2);
    adc_data_in[1*ADW +: ADW] = 8'($urandom);
    adc_data_ready[1] = 1'b1;
    step();
    adc_data_ready[1] = 1'b0;
    master_enable = 1'b0;
    step();
    master_enable = 1'b1;
    send_word(1, $urandom);
    serve(1);

    // Random single-word transactions
    for (int k = 0; k < 16; k++) begin
      ch = $urandom_range(0, NCH-1);
      signed_data[ch] = 1'($urandom);
      r = $urandom;
      send_word(ch, r);
      serve(ch);
    end
    signed_data = '0;

    // Overflow: arbiter parked on ch0 while ch3 receives 17 words
    term = 5'd1;
    send_word(0, $urandom);
    wait_start(0);
    term = 5'd31;
    for (int k = 0; k < 17; k++) send_word(3, $urandom);
    repeat (3) step();
    check("ovf_set", 32'(overflow), 32'(model_ovf));
    check("ovf_fifo_empty", 32'(fifo_empty), 32'b0111);
    repeat (5) step();
    check("ovf_sticky", 32'(overflow), 32'(model_ovf));
    channel_enable[3] = 1'b0;
    model_ovf[3] = 1'b0;
    step();
    check("ovf_cleared", 32'(overflow), 32'(model_ovf));
    channel_enable[3] = 1'b1;
    term = 5'd1;
    send_done();
    for (int k = 0; k < DEPTH; k++) serve(3);
    step();
    check("ovf_drained", 32'(fifo_empty), 32'hF);

    // Asynchronous reset while waiting for data_done with 5 words queued
    send_word(1, $urandom);
    wait_start(1);
    send_word(1, $urandom);
    send_word(1, $urandom);
    for (int k = 0; k < 3; k++) send_word(3, $urandom);
    repeat (3) step();
    check("wait_fifo_empty", 32'(fifo_empty), 32'b0101);
    #3;
    wb_rst = 1'b1;
    #1;
    check("arst_start", 32'(sram.start_sram), 32'd0);
    check("arst_fifo_empty", 32'(fifo_empty), 32'hF);
    check("arst_data_out", sram.data_out, 32'h0);
    check("arst_channel_id", 32'(sram.channel_id), 32'h0);
    step();
    wb_rst = 1'b0;
    clear_model();
    step();
    send_done();
    no_start(12, "done_after_reset");
    check("post_rst_empty", 32'(fifo_empty), 32'hF);
    term = 5'd16;
    send_word(2, $urandom);
    send_word(0, $urandom);
    step();
    step();
    term = 5'd1;
    serve(0);
    serve(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
